// File: rtl/fetch_pc.sv
// fetch_pc: program counter and instruction register stage that feeds the control FSM.
// Latency: an advance sampled at edge N gives a new PC and IMEM_REQ=1 after N; INSTR is loaded after the edge that samples IMEM_ACK=1 (at least 2 edges from advance to instruction).
// Backpressure: PC_WRITE is ignored while BUSY=1 (BOOT or REQ), with no queuing; the request is held until IMEM_ACK arrives.
//
// Ports:
//   CLK, RST (async, active-high), PC_RST (synchronous PC clear)
//   PC_WRITE/PC_SEL/BR_SEL   : advance command from the controller
//   IMEM_REQ/IMEM_ADDR       : fetch request towards instruction memory
//   IMEM_ACK/IMEM_DATA       : fetch response from instruction memory
//   PC, INSTR, OPCODE, MM, IR_VALID, BUSY, HALTED : status towards the controller
// Optional build macro FETCH_HALT_EN: fetching a word with opcode 4'hF latches HALTED.
// While HALTED is set, advances are blocked until RST or PC_RST.
module fetch_pc #(
  parameter int               PC_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PC_RST,
  input  logic            PC_WRITE,
  input  logic            PC_SEL,
  input  logic            BR_SEL,
  input  logic            IMEM_ACK,
  input  logic [31:0]     IMEM_DATA,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  output logic [PC_W-1:0] PC,
  output logic [31:0]     INSTR,
  output logic [3:0]      OPCODE,
  output logic [3:0]      MM,
  output logic            IR_VALID,
  output logic            BUSY,
  output logic            HALTED
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_IDLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            ir_valid_q, ir_valid_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] pc_next;
  logic            halt_blk;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  assign halt_blk = halted_q;
  assign HALTED   = halted_q;
`else
  assign halt_blk = 1'b0;
  assign HALTED   = 1'b0;
`endif

  // The low PC_W bits of the sign-extended 16-bit offset are simply
  // INSTR[PC_W-1:0] (PC_W <= 16), so relative and absolute targets share
  // the same slice; the add wraps mod 2^PC_W.
  always_comb begin
    pc_next = pc_q + PC_W'(1);
    if (PC_SEL) begin
      if (BR_SEL) pc_next = instr_q[PC_W-1:0];
      else        pc_next = pc_q + instr_q[PC_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
`ifdef FETCH_HALT_EN
    halted_d   = halted_q;
`endif
    if (PC_RST) begin
      // Abandons any in-flight request; INSTR is deliberately kept.
      state_d    = S_BOOT;
      pc_d       = RESET_PC;
      ir_valid_d = 1'b0;
      req_d      = 1'b0;
`ifdef FETCH_HALT_EN
      halted_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
        S_REQ: begin
          if (IMEM_ACK) begin
            instr_d    = IMEM_DATA;
            ir_valid_d = 1'b1;
            req_d      = 1'b0;
            state_d    = S_IDLE;
`ifdef FETCH_HALT_EN
            if (IMEM_DATA[31:28] == 4'hF) halted_d = 1'b1;
`endif
          end
        end
        S_IDLE: begin
          if (PC_WRITE && !halt_blk) begin
            pc_d       = pc_next;
            ir_valid_d = 1'b0;
            req_d      = 1'b1;
            state_d    = S_REQ;
          end
        end
        default: begin
          state_d = S_BOOT;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
`ifdef FETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign INSTR     = instr_q;
  assign OPCODE    = instr_q[31:28];
  assign MM        = instr_q[27:24];
  assign IR_VALID  = ir_valid_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule
